// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: three-stage pipelined carry-lookahead adder.
//   S1: per-bit generate/propagate/half-sum from gp_cell instances, plus cin.
//   S2: 4-bit group G/P, group-level lookahead, per-bit carries c[WIDTH:0].
//   S3: sum = x ^ c, cout and signed overflow.
// Each stage has a valid bit; readiness ripples back from out_ready so
// empty stages (bubbles) are filled even while downstream is stalled.

// Per-bit generate/propagate cell.
module gp_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic g,
  output logic p,
  output logic x
);
  assign g = a_bit & b_bit;
  assign p = a_bit | b_bit;
  assign x = a_bit ^ b_bit;
endmodule

module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NGRP = WIDTH / GROUP;

  // Stage valids and per-stage ready chain.
  logic v1_reg, v2_reg, v3_reg;
  logic r1, r2, r3;

  // Stage 1 data.
  logic [WIDTH-1:0] g_cell, p_cell, x_cell;
  logic [WIDTH-1:0] g1_reg, p1_reg, x1_reg;
  logic             cin1_reg;

  // Stage 2 combinational lookahead and registers.
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    c_grp;
  logic [WIDTH:0]   c_next;
  logic [WIDTH:0]   c2_reg;
  logic [WIDTH-1:0] x2_reg;

  // Stage 3 result registers.
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;

  // A stage may load when it is empty or its successor can take its content.
  assign r3       = ~v3_reg | out_ready;
  assign r2       = ~v2_reg | r3;
  assign r1       = ~v1_reg | r2;
  assign in_ready = r1;

  // One g/p/x cell per operand bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
      gp_cell u_gp (
        .a_bit (a[gi]),
        .b_bit (b[gi]),
        .g     (g_cell[gi]),
        .p     (p_cell[gi]),
        .x     (x_cell[gi])
      );
    end
  endgenerate

  // Group generate/propagate from the registered per-bit terms.
  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_groups
      localparam int B = gi * GROUP;
      assign grp_g[gi] = g1_reg[B+3]
                       | (p1_reg[B+3] & g1_reg[B+2])
                       | (p1_reg[B+3] & p1_reg[B+2] & g1_reg[B+1])
                       | (p1_reg[B+3] & p1_reg[B+2] & p1_reg[B+1] & g1_reg[B]);
      assign grp_p[gi] = &p1_reg[B+3:B];
    end
  endgenerate

  // Group-level carries, then per-bit carries by lookahead inside each group.
  always_comb begin
    c_grp    = '0;
    c_next   = '0;
    c_grp[0] = cin1_reg;
    for (int k = 0; k < NGRP; k++) begin
      c_grp[k+1] = grp_g[k] | (grp_p[k] & c_grp[k]);
    end
    c_next[0] = cin1_reg;
    for (int k = 0; k < NGRP; k++) begin
      c_next[k*GROUP+1] = g1_reg[k*GROUP]
                        | (p1_reg[k*GROUP] & c_grp[k]);
      c_next[k*GROUP+2] = g1_reg[k*GROUP+1]
                        | (p1_reg[k*GROUP+1] & g1_reg[k*GROUP])
                        | (p1_reg[k*GROUP+1] & p1_reg[k*GROUP] & c_grp[k]);
      c_next[k*GROUP+3] = g1_reg[k*GROUP+2]
                        | (p1_reg[k*GROUP+2] & g1_reg[k*GROUP+1])
                        | (p1_reg[k*GROUP+2] & p1_reg[k*GROUP+1] & g1_reg[k*GROUP])
                        | (p1_reg[k*GROUP+2] & p1_reg[k*GROUP+1] & p1_reg[k*GROUP]
                           & c_grp[k]);
      c_next[k*GROUP+4] = c_grp[k+1];
    end
  end

  // Stage 1: capture per-bit terms; data only moves when a valid op enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      g1_reg   <= '0;
      p1_reg   <= '0;
      x1_reg   <= '0;
      cin1_reg <= 1'b0;
    end else if (r1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        g1_reg   <= g_cell;
        p1_reg   <= p_cell;
        x1_reg   <= x_cell;
        cin1_reg <= cin;
      end
    end
  end

  // Stage 2: capture resolved carries and half-sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_reg <= 1'b0;
      c2_reg <= '0;
      x2_reg <= '0;
    end else if (r2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        c2_reg <= c_next;
        x2_reg <= x1_reg;
      end
    end
  end

  // Stage 3: final sum, carry out and signed overflow; held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_reg   <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (r3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        sum_reg  <= x2_reg ^ c2_reg[WIDTH-1:0];
        cout_reg <= c2_reg[WIDTH];
        ovf_reg  <= c2_reg[WIDTH] ^ c2_reg[WIDTH-1];
      end
    end
  end

  assign out_valid = v3_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: directed corner cases with literal results,
// backpressure and mid-stream reset scenarios, then a long random run.
// A monitor compares every delivered result against an arithmetic model.
module tb_cla_pipe_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // Expected results in delivery order, packed as {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Plain arithmetic: full-width sum with the extra bit as cout; signed
  // overflow when both operands share a sign that the result does not.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {o, t};
  endfunction

  // Monitor: check each delivered result against the model queue, check
  // stalled outputs hold, and record accepted operands.
  logic         stall_hold = 1'b0;
  logic [W+2:0] held_out = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_hold = 1'b0;
    end else begin
      if (stall_hold)
        check("stall_stable", {out_valid, ovf, cout, sum}, held_out);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {ovf, cout, sum}, '1);
        end else begin
          check("result", {ovf, cout, sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      stall_hold = out_valid && !out_ready;
      held_out   = {out_valid, ovf, cout, sum};
    end
  end

  // One op into an empty pipe; checks latency, literal result, single pulse.
  task automatic run_single(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input string name);
    int lat;
    bit seen;
    out_ready = 1'b1;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    lat = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) seen = 1;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_value"}, {ovf, cout, sum}, {eo, ec, es});
    @(posedge clk); #1;
    check({name, "_one_pulse"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_backpressure();
    int idx, acc;
    bit blocked, accept;
    logic [W-1:0] got_q[$];
    idx = 1; acc = 0; blocked = 0;
    for (int t = 1; t <= 40; t++) begin
      out_ready = !(t >= 4 && t <= 8);
      in_valid  = (idx <= 5);
      a = W'(idx); b = W'(idx); cin = 1'b0;
      #1;
      if (in_valid && !in_ready && !blocked) begin
        blocked = 1;
        check("bp_accepts_before_block", 64'(acc), 64'd3);
      end
      if (out_valid && out_ready) got_q.push_back(sum);
      accept = in_valid && in_ready;
      @(posedge clk); #1;
      if (accept) begin
        idx++;
        acc++;
      end
    end
    in_valid = 1'b0;
    check("bp_blocked_seen", 64'(blocked), 64'd1);
    check("bp_delivered_count", 64'(got_q.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size())
        check("bp_delivered_value", 64'(got_q[k]), 64'(2 * (k + 1)));
    end
  endtask

  task automatic run_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rst_pipe_full_valid", 64'(out_valid), 64'd1);
    check("rst_pipe_full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_cleared", {out_valid, ovf, cout, sum}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("rst_no_ghost", 64'(out_valid), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return '1;
      1: return '0;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset: nothing valid, outputs zero, always ready.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle", {out_valid, ovf, cout, in_ready, sum}, {1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    end

    run_single(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1");
    run_single(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "ripple");
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos");
    run_single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "ovf_neg");

    run_backpressure();
    run_reset_midstream();

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = pick_operand();
      b   = pick_operand();
      cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    // Drain everything still in flight.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Pipelined carry-lookahead adder. It is the direct downstream consumer of the per-bit generate/propagate cells: it instantiates one g/p cell per bit, registers their outputs, resolves carries with 4-bit lookahead groups and a group-level lookahead, and produces a registered sum.
- Sits between operand sources and the datapath result bus.
- Uses a valid/ready handshake on both sides, with per-stage bubble collapsing.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of GROUP, range 4..64.
- GROUP, 4, bits per lookahead group; fixed at 4 for this revision.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a/b/cin valid this cycle.
- in_ready  output  1  stage 1 can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum/cout/ovf valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:

Reset and clocking:
- Single clock domain. When rst_n=0 at a clk edge, the reset takes effect at that edge:
  - v1, v2, v3 (stage valids) clear to 0.
  - out_valid=0; sum=0, cout=0, ovf=0.
  - All internal data registers clear to 0.
- Reset mid-operation discards every in-flight result; no partial result is ever presented.

Pipeline:
- S1 registers g[i]=a[i]&b[i], p[i]=a[i]|b[i] and x[i]=a[i]^b[i] for all bits, plus cin. g and p come from per-bit g/p cells.
- S2 computes per-group G/P:
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - P = p3&p2&p1&p0
  - Group carries: c_grp[k+1] = G[k] | P[k]&c_grp[k], with c_grp[0]=cin.
  - Per-bit carries within each group by 4-bit lookahead from c_grp.
  - Registers c[WIDTH:0] and x.
- S3 registers sum = x ^ c[WIDTH-1:0], cout = c[WIDTH], ovf = c[WIDTH] ^ c[WIDTH-1]. sum, cout and ovf drive the outputs directly; out_valid = v3.

Latency and throughput:
- Latency is exactly 3 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid=1 after edge N+2, i.e. visible in cycle N+3, when no backpressure applies.
- Throughput is 1 result per cycle.

Handshake:
- Per-stage ready: r3 = ~v3 | out_ready; r2 = ~v2 | r3; r1 = ~v1 | r2; in_ready = r1.
- in_ready is combinational from out_ready and the valid registers. There is no combinational path from in_valid to in_ready.
- A stage loads when its ready is high. Its valid becomes the upstream valid, so bubbles collapse.
- A stalled stage holds its data and valid unchanged.
- While out_valid=1 and out_ready=0, sum/cout/ovf are stable.
- Simultaneous accept-in and deliver-out in one cycle is legal at full rate.
- in_valid=0 inserts a bubble; no register changes data when its valid is not being loaded. Gating data on load is permitted.
- With the pipeline full (v1=v2=v3=1) and out_ready=0, in_ready=0. Exactly 3 results are held.

Arithmetic:
- Unsigned wrap-around modulo 2^WIDTH; cout carries the lost bit.
- ovf is meaningful for two's-complement operands.
- No saturation.

Test Plan:
- Reset, then in_valid held low for 10 cycles -> out_valid=0, sum=0, cout=0, ovf=0 and in_ready=1 throughout.
- Single transaction a=0x0000_00FF, b=0x0000_0001, cin=0, with out_ready=1 -> out_valid high exactly 3 cycles after acceptance for 1 cycle; sum=0x0000_0100, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1. Then a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, ovf=1.
- Backpressure: stream 5 back-to-back ops a=i, b=i for i=1..5, with out_ready=0 for cycles 4-8 then 1.
  - in_ready drops after 3 accepts.
  - Results 2, 4, 6, 8, 10 are delivered in order, none lost or duplicated.
  - Outputs are stable while stalled.
- Reset mid-stream: 3 ops in flight, rst_n=0 for 1 cycle -> out_valid=0 the next cycle, and none of the 3 results ever appear. Random 10k ops with random in_valid/out_ready are then checked against a scoreboard using a+b+cin.
